// File: rtl/mont_pkg.sv
// Shared widths and FSM state encoding for the
// Montgomery modular-exponentiation controller.
package mont_pkg;

   localparam int DATA_W = 512;
   localparam int EXP_W  = 512;
   localparam int LEN_W  = 10;

   typedef enum logic [2:0] {
      IDLE,
      SQR_GO,
      SQR_WAIT,
      MUL_GO,
      MUL_WAIT,
      POST_GO,
      POST_WAIT,
      DONE
   } mont_state_e;

endpackage

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an
// external Montgomery multiplier; converts result out of domain.
module mont_exp_ctrl #(
   parameter int DATA_W = mont_pkg::DATA_W,
   parameter int EXP_W  = mont_pkg::EXP_W,
   parameter int LEN_W  = mont_pkg::LEN_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] in_x,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_m,
   input  logic [EXP_W-1:0]  in_e,
   input  logic [LEN_W-1:0]  in_e_len,
   output logic [DATA_W-1:0] result,
   output logic              busy,
   output logic              done,
   output logic              mont_start,
   output logic [DATA_W-1:0] mont_a,
   output logic [DATA_W-1:0] mont_b,
   output logic [DATA_W-1:0] mont_m,
   input  logic [DATA_W-1:0] mont_result,
   input  logic              mont_done
);
   import mont_pkg::*;

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   mont_state_e       state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] m_q, m_d;
   logic [EXP_W-1:0]  e_q, e_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [DATA_W-1:0] op_a_q, op_a_d;
   logic [DATA_W-1:0] op_b_q, op_b_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [LEN_W-1:0]  len_c;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      x_d     = x_q;
      m_d     = m_q;
      e_d     = e_q;
      idx_d   = idx_q;
      res_d   = res_q;
      len_c   = in_e_len;
      if (32'(in_e_len) > 32'(EXP_W)) begin
         len_c = LEN_W'(EXP_W);
      end

      unique case (state_q)
         IDLE: begin
            if (start) begin
               x_d = in_x;
               m_d = in_m;
               e_d = in_e;
               a_d = in_r;
               if (len_c != '0) begin
                  idx_d   = IDX_W'(len_c - 1'b1);
                  state_d = SQR_GO;
               end else begin
                  idx_d   = '0;
                  state_d = POST_GO;
               end
            end
         end
         SQR_GO:  state_d = SQR_WAIT;
         MUL_GO:  state_d = MUL_WAIT;
         POST_GO: state_d = POST_WAIT;
         SQR_WAIT: begin
            if (mont_done) begin
               a_d = mont_result;
               if (e_q[idx_q]) begin
                  state_d = MUL_GO;
               end else if (idx_q == '0) begin
                  state_d = POST_GO;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SQR_GO;
               end
            end
         end
         MUL_WAIT: begin
            if (mont_done) begin
               a_d = mont_result;
               if (idx_q == '0) begin
                  state_d = POST_GO;
               end else begin
                  idx_d   = idx_q - 1'b1;
                  state_d = SQR_GO;
               end
            end
         end
         POST_WAIT: begin
            if (mont_done) begin
               res_d   = mont_result;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are derived from the next state so they are registered.
      start_d = state_d inside {SQR_GO, MUL_GO, POST_GO};
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      unique case (state_d)
         SQR_GO: begin
            op_a_d = a_d;
            op_b_d = a_d;
         end
         MUL_GO: begin
            op_a_d = a_d;
            op_b_d = x_d;
         end
         POST_GO: begin
            op_a_d = a_d;
            op_b_d = ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         x_q     <= '0;
         m_q     <= '0;
         e_q     <= '0;
         idx_q   <= '0;
         res_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         x_q     <= x_d;
         m_q     <= m_d;
         e_q     <= e_d;
         idx_q   <= idx_d;
         res_q   <= res_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         start_q <= start_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign result     = res_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign mont_start = start_q;
   assign mont_a     = op_a_q;
   assign mont_b     = op_b_q;
   assign mont_m     = m_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Scoreboard bench for mont_exp_ctrl with a behavioural
// Montgomery multiplier of configurable latency.
module tb_mont_exp_ctrl;

   localparam int W  = 512;
   localparam int EW = 512;
   localparam int LW = 10;

   localparam logic [W-1:0] SM    = W'(32'hF1);
   localparam logic [W-1:0] SX    = W'(32'd7);
   localparam logic [W-1:0] BIG_M = {16{32'hDEADBEEF}};
   localparam logic [W-1:0] BIG_X = {16{32'h12345678}};

   typedef struct {
      logic [W-1:0] res;
      int           ops;
      int           lat;
      string        name;
   } exp_t;

   logic          clk;
   logic          reset;
   logic          start;
   logic [W-1:0]  in_x, in_r, in_m;
   logic [EW-1:0] in_e;
   logic [LW-1:0] in_e_len;
   logic [W-1:0]  result;
   logic          busy, done, mont_start;
   logic [W-1:0]  mont_a, mont_b, mont_m;
   logic [W-1:0]  mont_result;
   logic          mont_done;

   exp_t         sb[$];
   int           n_cmp = 0;
   int           n_err = 0;
   int           cyc = 0;
   int           ops_cnt = 0;
   int           ops_base = 0;
   int           start_cyc = 0;
   int           done_cnt = 0;
   int           lm_cfg = 1;
   logic [W-1:0] cur_m = '0;
   logic         prev_ms = 1'b0;

   mont_exp_ctrl #(.DATA_W(W), .EXP_W(EW), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset), .start(start),
      .in_x(in_x), .in_r(in_r), .in_m(in_m),
      .in_e(in_e), .in_e_len(in_e_len),
      .result(result), .busy(busy), .done(done),
      .mont_start(mont_start), .mont_a(mont_a),
      .mont_b(mont_b), .mont_m(mont_m),
      .mont_result(mont_result), .mont_done(mont_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] modmul(input logic [W-1:0] a,
         input logic [W-1:0] b, input logic [W-1:0] m);
      logic [W+1:0] r, mx, ax;
      r  = '0;
      mx = {2'b00, m};
      ax = {2'b00, a};
      for (int i = W - 1; i >= 0; i--) begin
         r = r << 1;
         if (r >= mx) r = r - mx;
         if (b[i]) begin
            r = r + ax;
            if (r >= mx) r = r - mx;
         end
      end
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] r_mod(input logic [W-1:0] m);
      logic [W+1:0] r, mx;
      r  = (W+2)'(1);
      mx = {2'b00, m};
      for (int i = 0; i < W; i++) begin
         r = r << 1;
         if (r >= mx) r = r - mx;
      end
      return r[W-1:0];
   endfunction

   function automatic logic [W-1:0] modexp(input logic [W-1:0] x,
         input logic [EW-1:0] e, input int len, input logic [W-1:0] m);
      logic [W-1:0] acc;
      acc = W'(1);
      for (int i = len - 1; i >= 0; i--) begin
         acc = modmul(acc, acc, m);
         if (e[i]) acc = modmul(acc, x, m);
      end
      return acc;
   endfunction

   function automatic logic [W-1:0] mont(input logic [W-1:0] a,
         input logic [W-1:0] b, input logic [W-1:0] m);
      logic [W+1:0] t, mx, bx;
      t  = '0;
      mx = {2'b00, m};
      bx = {2'b00, b};
      for (int i = 0; i < W; i++) begin
         if (a[i]) t = t + bx;
         if (t[0]) t = t + mx;
         t = t >> 1;
      end
      if (t >= mx) t = t - mx;
      return t[W-1:0];
   endfunction

   // External multiplier: answers lm_cfg cycles after mont_start.
   initial begin : mult_model
      logic [W-1:0] a, b, mm, res;
      logic         stable, aborted;
      mont_done   = 1'b0;
      mont_result = '0;
      forever begin
         @(negedge clk);
         mont_done = 1'b0;
         if (!reset && mont_start) begin
            a       = mont_a;
            b       = mont_b;
            mm      = mont_m;
            res     = mont(a, b, mm);
            stable  = (mm === cur_m);
            aborted = 1'b0;
            for (int k = 0; k < lm_cfg; k++) begin
               @(negedge clk);
               if (reset) begin
                  aborted = 1'b1;
                  break;
               end
               stable &= (mont_a === a) && (mont_b === b) &&
                         (mont_m === mm) && !mont_start;
            end
            if (!aborted) begin
               chk("op_stable", W'(stable), W'(1));
               mont_result = res;
               mont_done   = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (mont_start) begin
         ops_cnt++;
         chk("start_b2b", W'(prev_ms), W'(0));
      end
      prev_ms = mont_start;
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done) begin
         if (sb.size() == 0) begin
            chk("extra_done", W'(done), W'(0));
         end else begin
            e = sb.pop_front();
            chk({e.name, "_res"}, result, e.res);
            chk({e.name, "_ops"}, W'(ops_cnt - ops_base), W'(e.ops));
            chk({e.name, "_lat"}, W'(cyc - start_cyc + 1), W'(e.lat));
         end
         done_cnt++;
      end
   end

   task automatic run(input string nm, input logic [W-1:0] x,
         input logic [W-1:0] m, input logic [EW-1:0] e,
         input int len, input int lm, input logic [W-1:0] exp_res,
         input int exp_ops, input bit repulse);
      logic [W-1:0] rm;
      int           d0;
      bit           got;
      rm     = r_mod(m);
      lm_cfg = lm;
      cur_m  = m;
      d0     = done_cnt;
      sb.push_back('{exp_res, exp_ops, 2 + exp_ops * (1 + lm), nm});
      @(negedge clk);
      in_x      = modmul(x, rm, m);
      in_r      = rm;
      in_m      = m;
      in_e      = e;
      in_e_len  = LW'(len);
      start     = 1'b1;
      start_cyc = cyc;
      ops_base  = ops_cnt;
      @(negedge clk);
      start    = 1'b0;
      in_x     = '1;
      in_r     = '1;
      in_m     = '0;
      in_e     = '1;
      in_e_len = '1;
      if (repulse) begin
         repeat (5) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      got = 1'b0;
      for (int k = 0; k < 5000; k++) begin
         @(negedge clk);
         if (repulse) start = done;
         if (done_cnt != d0) begin
            got = 1'b1;
            break;
         end
      end
      @(negedge clk);
      start = 1'b0;
      if (!got) begin
         chk({nm, "_timeout"}, W'(0), W'(1));
         void'(sb.pop_front());
      end
      repeat (3) @(negedge clk);
      chk({nm, "_ndone"}, W'(done_cnt - d0), W'(1));
      chk({nm, "_idle"}, W'(busy), W'(0));
      chk({nm, "_hold"}, result, exp_res);
   endtask

   initial begin : stim
      logic [W-1:0] big_exp;
      reset    = 1'b1;
      start    = 1'b0;
      in_x     = '0;
      in_r     = '0;
      in_m     = '0;
      in_e     = '0;
      in_e_len = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_mstart", W'(mont_start), W'(0));
      chk("rst_result", result, W'(0));
      reset = 1'b0;
      @(negedge clk);

      run("len0", SX, SM, EW'(4'b1011), 0, 1, W'(1), 1, 1'b0);
      run("e1011", SX, SM, EW'(4'b1011), 4, 1, W'(68), 8, 1'b0);
      run("e1011_lm40", SX, SM, EW'(4'b1011), 4, 40, W'(68), 8, 1'b0);
      run("e0101", SX, SM, EW'(4'b0101), 4, 1, W'(178), 7, 1'b0);
      run("e_hi_ign", SX, SM, EW'(16'hFF0B), 4, 1, W'(68), 8, 1'b0);
      run("clamp", SX, SM, EW'(1), 600, 1, W'(7), 514, 1'b0);

      big_exp = modexp(BIG_X, EW'(17'h10001), 17, BIG_M);
      run("big", BIG_X, BIG_M, EW'(17'h10001), 17, 1, big_exp, 20, 1'b0);
      run("big_lm40", BIG_X, BIG_M, EW'(17'h10001), 17, 40, big_exp, 20,
          1'b0);

      run("repulse", SX, SM, EW'(4'b1011), 4, 40, W'(68), 8, 1'b1);

      // Abort mid-square, then confirm a clean rerun.
      lm_cfg = 40;
      cur_m  = SM;
      @(negedge clk);
      in_r     = r_mod(SM);
      in_x     = modmul(SX, in_r, SM);
      in_m     = SM;
      in_e     = EW'(4'b1011);
      in_e_len = LW'(4);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_busy", W'(busy), W'(0));
      chk("mid_rst_mstart", W'(mont_start), W'(0));
      chk("mid_rst_result", result, W'(0));
      chk("mid_rst_done", W'(done), W'(0));
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      run("after_rst", SX, SM, EW'(4'b1011), 4, 1, W'(68), 8, 1'b0);

      repeat (50) @(negedge clk);
      chk("sb_empty", W'(sb.size()), W'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
